avalon_reg_sequencer: RTL and testbench

AVALON_REG_SEQUENCER -- requirements
Module: avalon_reg_sequencer

---
 rtl/avalon_reg_sequencer.sv | 143 ++++++++++++++
 tb/tb_avalon_reg_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_reg_sequencer.sv
// Two-requester round-robin front end that turns single register accesses
// into Avalon-MM strobes and returns a one-cycle completion per request.
module avalon_reg_sequencer #(
  parameter int ADDR_W       = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [31:0]       req0_wdata,
  input  logic [3:0]        req0_be,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [31:0]       rsp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [31:0]       req1_wdata,
  input  logic [3:0]        req1_be,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [31:0]       rsp1_rdata,
  output logic              av_chipselect,
  output logic              av_write,
  output logic              av_read,
  output logic [ADDR_W-1:0] av_address,
  output logic [3:0]        av_byteenable,
  output logic [31:0]       av_writedata,
  input  logic [31:0]       av_readdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  state_t     state, state_nxt;
  logic       ptr;
  logic [2:0] cnt;
  logic       cap_write;
  logic       cap_id;
  logic       gnt1;
  logic       accept;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Grant goes to the lone valid requester, or to the pointer on a tie.
  always_comb begin
    gnt1          = req1_valid && (!req0_valid || ptr);
    accept        = (state == IDLE) && reset_n && (req0_valid || req1_valid);
    state_nxt     = state;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    av_chipselect = 1'b0;
    av_write      = 1'b0;
    av_read       = 1'b0;
    rsp0_valid    = 1'b0;
    rsp1_valid    = 1'b0;
    busy          = (state != IDLE);
    case (state)
      IDLE: begin
        if (accept) begin
          req0_ready = !gnt1;
          req1_ready = gnt1;
          state_nxt  = STROBE;
        end
      end
      STROBE: begin
        av_chipselect = 1'b1;
        av_write      = cap_write;
        av_read       = !cap_write;
        state_nxt     = cap_write ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt == LAT) state_nxt = RESP;
      end
      RESP: begin
        rsp0_valid = !cap_id;
        rsp1_valid = cap_id;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Captured request drives the Avalon bus directly; results land in the
  // per-requester rdata register on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr           <= 1'b0;
      cnt           <= 3'd0;
      cap_write     <= 1'b0;
      cap_id        <= 1'b0;
      av_address    <= '0;
      av_byteenable <= 4'h0;
      av_writedata  <= 32'h0;
      rsp0_rdata    <= 32'h0;
      rsp1_rdata    <= 32'h0;
    end else begin
      if (accept) begin
        cap_id <= gnt1;
        ptr    <= !gnt1;
        if (gnt1) begin
          cap_write     <= req1_write;
          av_address    <= req1_addr;
          av_writedata  <= req1_wdata;
          av_byteenable <= req1_write ? req1_be : 4'hF;
        end else begin
          cap_write     <= req0_write;
          av_address    <= req0_addr;
          av_writedata  <= req0_wdata;
          av_byteenable <= req0_write ? req0_be : 4'hF;
        end
      end
      case (state)
        STROBE: begin
          if (cap_write) begin
            if (cap_id) rsp1_rdata <= 32'h0;
            else        rsp0_rdata <= 32'h0;
          end else begin
            cnt <= 3'd1;
          end
        end
        WAIT: begin
          if (cnt == LAT) begin
            cnt <= 3'd0;
            if (cap_id) rsp1_rdata <= av_readdata;
            else        rsp0_rdata <= av_readdata;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_reg_sequencer.sv
// Bench for avalon_reg_sequencer: directed vector table, hand sequences for
// arbitration/reset/latency, and a randomized run against a cycle-index model.
module tb_avalon_reg_sequencer;

  localparam int LAT1 = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_valid = 1'b0, req0_write = 1'b0;
  logic [1:0]  req0_addr = '0;
  logic [31:0] req0_wdata = '0;
  logic [3:0]  req0_be = '0;
  logic        req1_valid = 1'b0, req1_write = 1'b0;
  logic [1:0]  req1_addr = '0;
  logic [31:0] req1_wdata = '0;
  logic [3:0]  req1_be = '0;
  logic [31:0] rdd = '0;

  wire         d1_rdy0, d1_rdy1, d1_rspv0, d1_rspv1, d1_cs, d1_wr, d1_rd, d1_busy;
  wire [31:0]  d1_rdata0, d1_rdata1, d1_wdata;
  wire [1:0]   d1_addr;
  wire [3:0]   d1_be;
  wire         d3_rdy0, d3_rdy1, d3_rspv0, d3_rspv1, d3_cs, d3_wr, d3_rd, d3_busy;
  wire [31:0]  d3_rdata0, d3_rdata1, d3_wdata;
  wire [1:0]   d3_addr;
  wire [3:0]   d3_be;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  avalon_reg_sequencer #(.ADDR_W(2), .READ_LATENCY(LAT1)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_be(req0_be), .req0_ready(d1_rdy0),
    .rsp0_valid(d1_rspv0), .rsp0_rdata(d1_rdata0),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_be(req1_be), .req1_ready(d1_rdy1),
    .rsp1_valid(d1_rspv1), .rsp1_rdata(d1_rdata1),
    .av_chipselect(d1_cs), .av_write(d1_wr), .av_read(d1_rd),
    .av_address(d1_addr), .av_byteenable(d1_be), .av_writedata(d1_wdata),
    .av_readdata(rdd), .busy(d1_busy)
  );

  avalon_reg_sequencer #(.ADDR_W(2), .READ_LATENCY(3)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_be(req0_be), .req0_ready(d3_rdy0),
    .rsp0_valid(d3_rspv0), .rsp0_rdata(d3_rdata0),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_be(req1_be), .req1_ready(d3_rdy1),
    .rsp1_valid(d3_rspv1), .rsp1_rdata(d3_rdata1),
    .av_chipselect(d3_cs), .av_write(d3_wr), .av_read(d3_rd),
    .av_address(d3_addr), .av_byteenable(d3_be), .av_writedata(d3_wdata),
    .av_readdata(rdd), .busy(d3_busy)
  );

  typedef struct {
    logic        wr;
    int          id;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] slave;
    logic [3:0]  exp_be;
    logic [31:0] exp_rdata;
    int          exp_off;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int id);
    return (id == 1) ? d1_rdy1 : d1_rdy0;
  endfunction
  function automatic logic rspv(input int id);
    return (id == 1) ? d1_rspv1 : d1_rspv0;
  endfunction
  function automatic logic [31:0] rdat(input int id);
    return (id == 1) ? d1_rdata1 : d1_rdata0;
  endfunction

  function automatic logic [31:0] slave_f(input int k);
    return (32'(k) * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  task automatic clear_reqs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic set_req(input int id, input logic wr, input logic [1:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
    if (id == 0) begin
      req0_valid = 1'b1; req0_write = wr; req0_addr = addr; req0_wdata = wdata; req0_be = be;
    end else begin
      req1_valid = 1'b1; req1_write = wr; req1_addr = addr; req1_wdata = wdata; req1_be = be;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_reqs();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    set_req(v.id, v.wr, v.addr, v.wdata, v.be);
    rdd = ~v.slave;
    #1;
    chk({t, "_ready"}, 32'(rdy(v.id)), 32'd1);
    chk({t, "_ready_other"}, 32'(rdy(1 - v.id)), 32'd0);
    tick();
    clear_reqs();
    for (int o = 1; o <= v.exp_off + 1; o++) begin
      rdd = (o == 2) ? v.slave : ~v.slave;
      #1;
      if (o == 1) begin
        chk({t, "_cs"}, 32'(d1_cs), 32'd1);
        chk({t, "_write"}, 32'(d1_wr), 32'(v.wr));
        chk({t, "_read"}, 32'(d1_rd), 32'(!v.wr));
        chk({t, "_addr"}, 32'(d1_addr), 32'(v.addr));
        chk({t, "_be"}, 32'(d1_be), 32'(v.exp_be));
        chk({t, "_wdata"}, d1_wdata, v.wdata);
      end else begin
        chk({t, "_cs_off"}, 32'(d1_cs), 32'd0);
      end
      chk({t, "_rsp"}, 32'(rspv(v.id)), 32'(o == v.exp_off));
      chk({t, "_rsp_other"}, 32'(rspv(1 - v.id)), 32'd0);
      if (o == v.exp_off) chk({t, "_rdata"}, rdat(v.id), v.exp_rdata);
      if (o == v.exp_off + 1) chk({t, "_idle"}, 32'(d1_busy), 32'd0);
      tick();
    end
  endtask

  int          m_busy_end, m_strobe, m_rsp, m_ptr, m_id, g, grants, exp_g;
  logic        m_wr, idle;
  logic [1:0]  m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic [31:0] m_rdata [2];

  task automatic model_reset();
    m_busy_end = -1; m_strobe = -1; m_rsp = -1; m_ptr = 0; m_id = 0;
    m_wr = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0;
    m_rdata[0] = '0; m_rdata[1] = '0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 0, 2'd1, 32'hDEADBEEF, 4'hF, 32'h0,        4'hF, 32'h0,        2};
    vecs[1] = '{1'b0, 1, 2'd2, 32'h0,        4'h0, 32'h12345678, 4'hF, 32'h12345678, 3};
    vecs[2] = '{1'b1, 1, 2'd3, 32'hAABBCCDD, 4'h5, 32'h0,        4'h5, 32'h0,        2};
    vecs[3] = '{1'b1, 0, 2'd0, 32'h11223344, 4'h0, 32'h0,        4'h0, 32'h0,        2};
    vecs[4] = '{1'b0, 0, 2'd3, 32'h0,        4'h3, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 3};

    // reset state, with requests pending to show ready is held off
    reset_n = 1'b0;
    tick();
    tick();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rst_busy", 32'(d1_busy), 32'd0);
    chk("rst_strobes", {29'd0, d1_cs, d1_wr, d1_rd}, 32'd0);
    chk("rst_addr_be", {26'd0, d1_addr, d1_be}, 32'd0);
    chk("rst_wdata", d1_wdata, 32'd0);
    chk("rst_ready", {30'd0, d1_rdy1, d1_rdy0}, 32'd0);
    chk("rst_rsp", {30'd0, d1_rspv1, d1_rspv0}, 32'd0);
    chk("rst_rdata", d1_rdata0 | d1_rdata1, 32'd0);
    chk("rst3_all", {26'd0, d3_busy, d3_cs, d3_rdy0, d3_rdy1, d3_rspv0, d3_rspv1}, 32'd0);
    clear_reqs();
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // both requesters valid continuously: grants alternate starting at 0
    do_reset();
    set_req(0, 1'b1, 2'd0, 32'h0A0A0A0A, 4'hF);
    set_req(1, 1'b1, 2'd1, 32'h0B0B0B0B, 4'hF);
    grants = 0;
    exp_g = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      chk($sformatf("rr_not_both_c%0d", c), 32'(d1_rdy0 && d1_rdy1), 32'd0);
      if (d1_rdy0 || d1_rdy1) begin
        chk($sformatf("rr_grant%0d", grants), 32'(d1_rdy1), 32'(exp_g));
        exp_g = 1 - exp_g;
        grants++;
      end
      tick();
    end
    chk("rr_grant_count", 32'(grants), 32'd4);
    clear_reqs();
    tick(); tick(); tick();

    // reset during WAIT aborts the read; pointer returns to requester 0
    do_reset();
    set_req(0, 1'b0, 2'd2, 32'h0, 4'hF);
    tick();
    clear_reqs();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    set_req(0, 1'b1, 2'd1, 32'h55, 4'hF);
    set_req(1, 1'b1, 2'd1, 32'h66, 4'hF);
    #1;
    chk("abort_busy", 32'(d1_busy), 32'd0);
    chk("abort_strobes", {29'd0, d1_cs, d1_wr, d1_rd}, 32'd0);
    chk("abort_rsp", {30'd0, d1_rspv1, d1_rspv0}, 32'd0);
    chk("abort_grant", {30'd0, d1_rdy1, d1_rdy0}, 32'd1);
    chk("abort3_state", {27'd0, d3_busy, d3_cs, d3_rspv0, d3_rspv1, d3_rd}, 32'd0);
    chk("abort3_grant", {30'd0, d3_rdy1, d3_rdy0}, 32'd1);
    tick();
    clear_reqs();
    for (int c = 0; c < 6; c++) tick();

    // latency 1 vs 3: each samples a different cycle's read data
    do_reset();
    set_req(0, 1'b0, 2'd1, 32'h0, 4'h0);
    tick();
    clear_reqs();
    for (int o = 1; o <= 6; o++) begin
      rdd = 32'h100 + 32'(o);
      #1;
      if (o == 1) chk("lat3_strobe", {28'd0, d3_cs, d3_rd, d3_be == 4'hF, d3_wr}, 32'hE);
      chk($sformatf("lat1_rsp_o%0d", o), 32'(d1_rspv0), 32'(o == 3));
      chk($sformatf("lat3_rsp_o%0d", o), 32'(d3_rspv0), 32'(o == 5));
      if (o == 3) chk("lat1_rdata", d1_rdata0, 32'h102);
      if (o == 5) chk("lat3_rdata", d3_rdata0, 32'h104);
      tick();
    end

    // randomized run against the cycle-index model
    do_reset();
    model_reset();
    for (int k = 0; k < 600; k++) begin
      reset_n    = ($urandom_range(0, 39) != 0);
      req0_valid = ($urandom_range(0, 2) != 0);
      req0_write = 1'($urandom_range(0, 1));
      req0_addr  = 2'($urandom_range(0, 3));
      req0_wdata = $urandom;
      req0_be    = 4'($urandom_range(0, 15));
      req1_valid = ($urandom_range(0, 2) != 0);
      req1_write = 1'($urandom_range(0, 1));
      req1_addr  = 2'($urandom_range(0, 3));
      req1_wdata = $urandom;
      req1_be    = 4'($urandom_range(0, 15));
      rdd        = slave_f(k);
      #1;
      idle = (k > m_busy_end);
      g = -1;
      if (idle && reset_n && (req0_valid || req1_valid))
        g = (req0_valid && req1_valid) ? m_ptr : (req1_valid ? 1 : 0);
      if (k == m_rsp) m_rdata[m_id] = m_wr ? 32'h0 : slave_f(m_strobe + LAT1);
      chk($sformatf("rnd%0d_ready0", k), 32'(d1_rdy0), 32'(g == 0));
      chk($sformatf("rnd%0d_ready1", k), 32'(d1_rdy1), 32'(g == 1));
      chk($sformatf("rnd%0d_busy", k), 32'(d1_busy), 32'(!idle));
      chk($sformatf("rnd%0d_cs", k), 32'(d1_cs), 32'(k == m_strobe));
      chk($sformatf("rnd%0d_write", k), 32'(d1_wr), 32'(k == m_strobe && m_wr));
      chk($sformatf("rnd%0d_read", k), 32'(d1_rd), 32'(k == m_strobe && !m_wr));
      chk($sformatf("rnd%0d_addr", k), 32'(d1_addr), 32'(m_addr));
      chk($sformatf("rnd%0d_be", k), 32'(d1_be), 32'(m_be));
      chk($sformatf("rnd%0d_wdata", k), d1_wdata, m_wdata);
      chk($sformatf("rnd%0d_rsp0", k), 32'(d1_rspv0), 32'(k == m_rsp && m_id == 0));
      chk($sformatf("rnd%0d_rsp1", k), 32'(d1_rspv1), 32'(k == m_rsp && m_id == 1));
      chk($sformatf("rnd%0d_rdata0", k), d1_rdata0, m_rdata[0]);
      chk($sformatf("rnd%0d_rdata1", k), d1_rdata1, m_rdata[1]);
      if (!reset_n) begin
        model_reset();
      end else if (g >= 0) begin
        m_id     = g;
        m_wr     = (g == 1) ? req1_write : req0_write;
        m_addr   = (g == 1) ? req1_addr : req0_addr;
        m_wdata  = (g == 1) ? req1_wdata : req0_wdata;
        m_be     = m_wr ? ((g == 1) ? req1_be : req0_be) : 4'hF;
        m_strobe = k + 1;
        m_rsp    = k + 2 + (m_wr ? 0 : LAT1);
        m_busy_end = m_rsp;
        m_ptr    = 1 - g;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
